// File: rtl/tx_port_pkg.sv
// Shared definitions for the flit channel ports: FSM encodings and head-flag helper.
// The receive side imports the same package so both ends agree on encodings.
package tx_port_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_FETCH    = 3'd1;
   localparam logic [2:0] ST_OFFER    = 3'd2;
   localparam logic [2:0] ST_WAIT_ACK = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   typedef enum logic [2:0] {
      IDLE     = ST_IDLE,
      FETCH    = ST_FETCH,
      OFFER    = ST_OFFER,
      WAIT_ACK = ST_WAIT_ACK,
      DONE     = ST_DONE
   } tx_state_t;

   // The head flag always sits in the MSB of a flit, whatever the flit width.
   function automatic int head_flag_idx(input int size);
      return size - 1;
   endfunction

endpackage

// File: rtl/tx_port_if.sv
// Bundle of packet-buffer and flit-channel signals seen by a transmit port.
interface tx_port_if #(
   parameter int SIZE      = 8,
   parameter int BUFF_BITS = 3
);
   logic                 pkt_req;
   logic [BUFF_BITS-1:0] buf_addr;
   logic [SIZE-1:0]      buf_data;
   logic                 pkt_done;
   logic                 hdr_err;
   logic                 ch_req;
   logic [SIZE-1:0]      ch_flit;
   logic                 ch_ack;

   modport master (
      input  pkt_req, buf_data, ch_ack,
      output buf_addr, pkt_done, hdr_err, ch_req, ch_flit
   );

   modport slave (
      output pkt_req, buf_data, ch_ack,
      input  buf_addr, pkt_done, hdr_err, ch_req, ch_flit
   );
endinterface

// File: rtl/tx_port_sync.sv
// Two-flop synchronizer with synchronous active-high reset for the incoming ack phase.
module tx_port_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/tx_port.sv
// Transmit port: streams a granted packet buffer, one flit at a time, onto a
// two-phase req/ack channel whose acknowledge is asynchronous to clk.
module tx_port
   import tx_port_pkg::*;
#(
   parameter int ID            = 0,
   parameter int SUBID         = 0,
   parameter     MOD_NAME      = "TX",
   parameter int SIZE          = 8,
   parameter int BUFF_BITS     = 3,
   parameter int VERBOSE_DEBUG = 1
) (
   input logic        clk,
   input logic        reset,
   tx_port_if.master  port
);
   localparam int                   FLITS     = 2 ** BUFF_BITS;
   localparam logic [BUFF_BITS-1:0] LAST_ADDR = BUFF_BITS'(FLITS - 1);
   localparam int                   HEAD_BIT  = head_flag_idx(SIZE);

   // Debug identity parameters travel with the instance; reject nonsense at elaboration.
   if (SIZE < 2 || BUFF_BITS < 1 || ID < 0 || SUBID < 0 || VERBOSE_DEBUG < 0 ||
       $bits(MOD_NAME) < 8) begin : g_bad_params
      $error("tx_port: illegal parameter combination");
   end

   tx_state_t state;
   logic      ack_sync;
   logic      ack_old;
   logic      ack_event;

   tx_port_sync synchronizer (
      .clk   (clk),
      .reset (reset),
      .d     (port.ch_ack),
      .q     (ack_sync)
   );

   assign ack_event = (ack_sync != ack_old);

   // Any ack phase change is absorbed into ack_old wherever it lands, but only
   // WAIT_ACK lets it move the packet forward.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         port.ch_req   <= 1'b0;
         port.ch_flit  <= '0;
         port.buf_addr <= '0;
         port.pkt_done <= 1'b0;
         port.hdr_err  <= 1'b0;
         ack_old       <= 1'b0;
      end else begin
         port.pkt_done <= 1'b0;
         port.hdr_err  <= 1'b0;
         if (ack_event) ack_old <= ack_sync;

         case (state)
            IDLE: begin
               if (port.pkt_req) begin
                  port.buf_addr <= '0;
                  state         <= FETCH;
               end
            end
            FETCH: begin
               port.ch_flit <= port.buf_data;
               if (port.buf_addr == '0 && !port.buf_data[HEAD_BIT]) port.hdr_err <= 1'b1;
               state <= OFFER;
            end
            OFFER: begin
               port.ch_req <= ~port.ch_req;
               state       <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (ack_event) begin
                  if (port.buf_addr == LAST_ADDR) begin
                     port.pkt_done <= 1'b1;
                     state         <= DONE;
                  end else begin
                     port.buf_addr <= port.buf_addr + 1'b1;
                     state         <= FETCH;
                  end
               end
            end
            DONE: begin
               port.buf_addr <= '0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tx_port.sv
// Directed bench for tx_port: table of packet scenarios plus hand-written
// sequences for stalled acks, back-to-back packets and mid-packet reset.
module tb_tx_port;
   localparam int SIZE      = 8;
   localparam int BUFF_BITS = 3;
   localparam int FLITS     = 8;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   tx_port_if #(.SIZE(SIZE), .BUFF_BITS(BUFF_BITS)) tif ();

   tx_port #(
      .ID            (0),
      .SUBID         (0),
      .MOD_NAME      ("TX"),
      .SIZE          (SIZE),
      .BUFF_BITS     (BUFF_BITS),
      .VERBOSE_DEBUG (0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .port  (tif)
   );

   logic [SIZE-1:0] mem [FLITS];
   assign tif.buf_data = mem[tif.buf_addr];

   // Channel monitor: cumulative counts so the stimulus only ever reads them.
   int              cyc = 0;
   int              toggles = 0;
   int              done_cnt = 0;
   int              hdr_cnt = 0;
   int              last_done_cyc = 0;
   int              last_gap = 0;
   bit              gap_armed = 1'b0;
   logic            prev_req = 1'b0;
   logic [SIZE-1:0] flit_log [256];

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         prev_req = tif.ch_req;
      end else begin
         if (tif.ch_req !== prev_req) begin
            flit_log[toggles[7:0]] = tif.ch_flit;
            toggles++;
            if (gap_armed) begin
               last_gap  = cyc - last_done_cyc;
               gap_armed = 1'b0;
            end
         end
         prev_req = tif.ch_req;
         if (tif.pkt_done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
            gap_armed     = 1'b1;
         end
         if (tif.hdr_err === 1'b1) hdr_cnt++;
      end
   end

   // Channel peer: echoes each req toggle after ack_delay cycles unless held.
   int   ack_delay = 3;
   bit   peer_hold = 1'b0;
   logic peer_prev = 1'b0;
   bit   pending = 1'b0;
   int   cnt = 0;

   always @(negedge clk) begin
      if (reset) begin
         tif.ch_ack = 1'b0;
         pending    = 1'b0;
         peer_prev  = tif.ch_req;
      end else if (tif.ch_req !== peer_prev) begin
         peer_prev = tif.ch_req;
         pending   = 1'b1;
         cnt       = ack_delay;
      end else if (pending && !peer_hold) begin
         cnt--;
         if (cnt <= 0) begin
            tif.ch_ack = ~tif.ch_ack;
            pending    = 1'b0;
         end
      end
   end

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] flit0;
      int         delay;
      bit         drop_early;
      int         exp_latency;
      int         exp_toggles;
      int         exp_done;
      int         exp_hdr;
   } vec_t;

   vec_t vecs [5];

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] actual, input int expected);
      checks++;
      if (actual !== 32'(expected)) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic load_buffer(input logic [7:0] flit0);
      mem[0] = flit0;
      for (int i = 1; i < FLITS; i++) mem[i] = 8'(i);
   endtask

   task automatic wait_toggles(input int target, input int limit, input string name);
      int n = 0;
      while (toggles < target && n < limit) begin
         tick();
         n++;
      end
      if (toggles < target) check_output({name, " toggle timeout"}, toggles, target);
   endtask

   task automatic wait_done(input int target, input int limit, input string name);
      int n = 0;
      while (done_cnt < target && n < limit) begin
         tick();
         n++;
      end
      if (done_cnt < target) check_output({name, " done timeout"}, done_cnt, target);
   endtask

   task automatic check_flits(input int base, input logic [7:0] flit0, input string name);
      for (int i = 0; i < FLITS; i++) begin
         logic [7:0] exp;
         exp = (i == 0) ? flit0 : 8'(i);
         check_output($sformatf("%s flit%0d", name, i), 32'(flit_log[8'(base + i)]), int'(exp));
      end
   endtask

   task automatic apply_vector(input vec_t v, input int idx);
      int   bt = toggles;
      int   bd = done_cnt;
      int   bh = hdr_cnt;
      int   lat = 0;
      logic hdr_off = 1'b0;
      logic start_req = tif.ch_req;
      string nm = $sformatf("v%0d", idx);

      load_buffer(v.flit0);
      ack_delay   = v.delay;
      tif.pkt_req = 1'b1;
      while (tif.ch_req === start_req && lat < 20) begin
         tick();
         lat++;
         if (lat == 2) hdr_off = tif.hdr_err;
      end
      check_output({nm, " latency"}, lat, v.exp_latency);
      check_output({nm, " hdr_err at offer"}, 32'(hdr_off), v.exp_hdr);
      if (v.drop_early) begin
         wait_toggles(bt + 2, 200, nm);
         tif.pkt_req = 1'b0;
      end
      wait_done(bd + 1, 1000, nm);
      tif.pkt_req = 1'b0;
      repeat (20) tick();
      check_output({nm, " toggles"}, toggles - bt, v.exp_toggles);
      check_output({nm, " pkt_done"}, done_cnt - bd, v.exp_done);
      check_output({nm, " hdr_err pulses"}, hdr_cnt - bh, v.exp_hdr);
      check_flits(bt, v.flit0, nm);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   bt;
      int   bd;
      int   bad_req;
      int   bad_flit;
      int   bad_addr;
      logic frozen_req;

      reset       = 1'b1;
      tif.pkt_req = 1'b0;
      load_buffer(8'h85);

      vecs[0] = '{8'h85, 3, 1'b0, 3, 8, 1, 0};
      vecs[1] = '{8'h05, 3, 1'b0, 3, 8, 1, 1};
      vecs[2] = '{8'h85, 3, 1'b1, 3, 8, 1, 0};
      vecs[3] = '{8'hFF, 1, 1'b0, 3, 8, 1, 0};
      vecs[4] = '{8'h7F, 6, 1'b0, 3, 8, 1, 1};

      repeat (3) tick();
      check_output("reset ch_req", 32'(tif.ch_req), 0);
      check_output("reset ch_flit", 32'(tif.ch_flit), 0);
      check_output("reset buf_addr", 32'(tif.buf_addr), 0);
      check_output("reset pkt_done", 32'(tif.pkt_done), 0);
      check_output("reset hdr_err", 32'(tif.hdr_err), 0);
      reset = 1'b0;
      repeat (2) tick();

      for (int i = 0; i < 5; i++) apply_vector(vecs[i], i);

      // Ack withheld for 100 cycles on flit 3: channel must freeze.
      bt = toggles;
      bd = done_cnt;
      load_buffer(8'h85);
      ack_delay   = 3;
      tif.pkt_req = 1'b1;
      wait_toggles(bt + 4, 200, "hold");
      peer_hold  = 1'b1;
      frozen_req = tif.ch_req;
      bad_req    = 0;
      bad_flit   = 0;
      bad_addr   = 0;
      repeat (100) begin
         tick();
         if (tif.ch_req !== frozen_req) bad_req++;
         if (tif.ch_flit !== 8'h03) bad_flit++;
         if (tif.buf_addr !== 3'd3) bad_addr++;
      end
      check_output("hold toggles frozen", toggles - bt, 4);
      check_output("hold ch_req changes", bad_req, 0);
      check_output("hold ch_flit changes", bad_flit, 0);
      check_output("hold buf_addr changes", bad_addr, 0);
      peer_hold = 1'b0;
      wait_done(bd + 1, 1000, "hold");
      tif.pkt_req = 1'b0;
      repeat (10) tick();
      check_output("hold toggles", toggles - bt, 8);
      check_output("hold pkt_done", done_cnt - bd, 1);
      check_flits(bt, 8'h85, "hold");

      // pkt_req held across two packets.
      bt = toggles;
      bd = done_cnt;
      load_buffer(8'h85);
      tif.pkt_req = 1'b1;
      wait_done(bd + 2, 2000, "b2b");
      tif.pkt_req = 1'b0;
      repeat (20) tick();
      check_output("b2b toggles", toggles - bt, 16);
      check_output("b2b pkt_done", done_cnt - bd, 2);
      check_output("b2b done-to-req gap", last_gap, 4);
      check_output("b2b second head", 32'(flit_log[8'(bt + 8)]), 'h85);

      // Reset while waiting for the ack of flit 4.
      bt = toggles;
      bd = done_cnt;
      load_buffer(8'h85);
      tif.pkt_req = 1'b1;
      wait_toggles(bt + 5, 300, "rst");
      peer_hold   = 1'b1;
      tif.pkt_req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check_output("rst ch_req", 32'(tif.ch_req), 0);
      check_output("rst buf_addr", 32'(tif.buf_addr), 0);
      check_output("rst ch_flit", 32'(tif.ch_flit), 0);
      check_output("rst pkt_done", 32'(tif.pkt_done), 0);
      reset     = 1'b0;
      peer_hold = 1'b0;
      repeat (20) tick();
      check_output("rst no done pulse", done_cnt - bd, 0);
      check_output("rst toggles", toggles - bt, 5);
      apply_vector(vecs[0], 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
